wide_op_sequencer: RTL and testbench
====================================

# wide_op_sequencer

Multi-cycle 64-bit operation sequencer that sits directly upstream of the 32-bit ALU. It accepts one 64-bit request at a time, drives the ALU's operand, function-select and write-enable inputs for two consecutive word steps, and chains the carry through the ALU flag register between steps. It then returns a 64-bit result with 64-bit-correct flags.

## Interface
Parameters: none (widths fixed at 64-bit request, 32-bit ALU).
- Clock  in  1  rising-edge clock, shared with the ALU
- Reset  in  1  asynchronous, active-low
- ReqValid  in  1  request present
- ReqReady  out  1  sequencer can accept (high only in IDLE)
- ReqOp  in  3  0 ADD, 1 SHL, 2 SHR, 3 AND, 4 OR, 5 XOR, 6–7 illegal
- ReqA  in  64  operand A
- ReqB  in  64  operand B (ignored for SHL/SHR)
- AluA  out  32  to ALU A
- AluB  out  32  to ALU B
- AluFunSel  out  5  to ALU FunSel
- AluWF  out  1  to ALU WF
- AluOut  in  32  ALU result
- AluFlags  in  4  ALU flags {Z,C,N,V}
- ResValid  out  1  result present
- ResReady  in  1  consumer accepts result
- Result  out  64  64-bit result
- ResFlags  out  4  {Z,C,N,V} for the 64-bit operation
- Busy  out  1  state != IDLE

## Operation
- States: IDLE → STEP1 → STEP2 → CAPT → DONE → IDLE.
- Request handshake:
  - In IDLE, ReqValid&ReqReady latches ReqOp, ReqA and ReqB.
  - Other states ignore ReqValid.
- STEP1/STEP2 drive AluWF=1 and the following FunSel/word schedule:
  - ADD: STEP1 10100 on low words; STEP2 10101 on high words (ADC uses the carry from STEP1).
  - SHL: STEP1 11011 on A low; STEP2 11110 on A high (CSL shifts in the carry, which equals A[31]).
  - SHR: STEP1 11100 on A high; STEP2 11111 on A low (CSR shifts in the carry, which equals A[32]).
  - AND/OR/XOR: 10111/11000/11001; low word then high word.
  - Illegal op: 10000 on both steps, so Result=ReqA.
- Every STEP1 FunSel is carry-independent. Stale ALU carry after reset therefore never reaches a result.
- ALU output capture:
  - AluOut is sampled at the end of each step into the word slot that step addresses.
  - SHR writes the high slot first.
- IDLE, CAPT and DONE drive AluFunSel=10000, AluWF=0, AluA=AluB=0. The ALU holds C and V under this FunSel.
- CAPT latches AluFlags C and V, which reflect STEP2.
- ResFlags:
  - Z = (Result==0), computed locally.
  - N = Result[63].
  - C = latched C for ADD/SHL/SHR, else 0.
  - V = latched V for ADD only, else 0.
- DONE holds ResValid=1 with Result and ResFlags stable until ResReady. The handshake cycle returns to IDLE.

## Timing
- Reset values:
  - state IDLE, ReqReady=1, ResValid=0, Busy=0.
  - Result=0, ResFlags=0.
  - AluFunSel=10000, AluWF=0, AluA=AluB=0.
- Latency:
  - Request accepted at edge t0.
  - STEP1 in cycle t0+1, STEP2 in t0+2, CAPT in t0+3.
  - ResValid rises in cycle t0+4.
- Throughput: at most one request per 5 cycles with ResReady held high. The next ReqReady is the cycle after the DONE handshake.
- ResReady held low: stays in DONE indefinitely; outputs unchanged.
- ResReady high on the first DONE cycle: that cycle completes the handshake.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded. The ALU is not reset; no flag dependence results (see STEP1 rule).
- All outputs are registered. Nothing is combinational from ReqValid or ResReady to any output, except the state-derived ReqReady.

## Structure
- Shared package wide_op_pkg holds:
  - op codes (ADD..XOR);
  - ALU FunSel constants used here (10000, 10100, 10101, 10111, 11000, 11001, 11011, 11100, 11110, 11111);
  - flag bit indices Z=3, C=2, N=1, V=0;
  - state enum.
- One sub-module, wide_op_decode (combinational): ReqOp → {funsel1, funsel2, high_first, uses_carry, uses_overflow}.
- The FSM, operand/result registers and ALU drive logic live in wide_op_sequencer.

## Test plan
- ADD 0x00000000_FFFFFFFF + 0x1 → Result 0x00000001_00000000, ResFlags 0000; ResValid exactly 4 cycles after accept.
- ADD 0x7FFFFFFF_FFFFFFFF + 0x1 → 0x80000000_00000000, N=1, V=1, C=0; ADD 0xFFFFFFFF_FFFFFFFF + 0x1 → 0, Z=1, C=1.
- SHL 0x80000000_80000000 → 0x00000001_00000000, C=1; SHR 0x00000001_00000001 → 0x00000000_80000000, C=1.
- XOR 0x0F0F0F0F_F0F0F0F0 with itself → 0, ResFlags 1000; illegal op 7 with A=0x12345678_9ABCDEF0 → Result=A, C=V=0.
- Backpressure: ResReady low 10 cycles → ResValid, Result and ResFlags stable, ReqReady=0, second ReqValid ignored; accepted the cycle after the handshake.
- Reset pulled low during STEP2 → all outputs at reset values immediately; the next ADD 1+1 → 2 with C=0, despite a prior ALU carry of 1.

Source files
------------

// File: rtl/wide_op_pkg.sv
// Shared definitions for the 64-bit operation sequencer: op codes, the ALU
// function-select codes it issues, flag bit positions and FSM states.
package wide_op_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam logic [4:0] FS_PASS = 5'b10000;
  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_ADC  = 5'b10101;
  localparam logic [4:0] FS_AND  = 5'b10111;
  localparam logic [4:0] FS_OR   = 5'b11000;
  localparam logic [4:0] FS_XOR  = 5'b11001;
  localparam logic [4:0] FS_LSL  = 5'b11011;
  localparam logic [4:0] FS_LSR  = 5'b11100;
  localparam logic [4:0] FS_CSL  = 5'b11110;
  localparam logic [4:0] FS_CSR  = 5'b11111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STEP1 = 3'd1,
    ST_STEP2 = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/wide_op_decode.sv
// Maps a request op code to its two-step ALU schedule and to which ALU
// flags are meaningful for the 64-bit result.
module wide_op_decode
  import wide_op_pkg::*;
(
  input  logic [2:0] op,
  output logic [4:0] funsel1,
  output logic [4:0] funsel2,
  output logic       high_first,
  output logic       uses_carry,
  output logic       uses_overflow
);

  // Step 1 never reads the ALU carry, so a stale carry cannot leak into a result.
  always_comb begin
    funsel1       = FS_PASS;
    funsel2       = FS_PASS;
    high_first    = 1'b0;
    uses_carry    = 1'b0;
    uses_overflow = 1'b0;
    case (op)
      OP_ADD: begin
        funsel1       = FS_ADD;
        funsel2       = FS_ADC;
        uses_carry    = 1'b1;
        uses_overflow = 1'b1;
      end
      OP_SHL: begin
        funsel1    = FS_LSL;
        funsel2    = FS_CSL;
        uses_carry = 1'b1;
      end
      OP_SHR: begin
        funsel1    = FS_LSR;
        funsel2    = FS_CSR;
        high_first = 1'b1;
        uses_carry = 1'b1;
      end
      OP_AND: begin
        funsel1 = FS_AND;
        funsel2 = FS_AND;
      end
      OP_OR: begin
        funsel1 = FS_OR;
        funsel2 = FS_OR;
      end
      OP_XOR: begin
        funsel1 = FS_XOR;
        funsel2 = FS_XOR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wide_op_sequencer.sv
// Drives a 32-bit ALU through two word steps to perform one 64-bit operation,
// chaining the carry through the ALU flag register between the steps.
//
// state    | meaning
// ST_IDLE  | ready for a request, ALU held in pass mode with WF=0
// ST_STEP1 | first word step on the ALU (carry-independent function)
// ST_STEP2 | second word step, consumes the carry produced by step 1
// ST_CAPT  | ALU flags now reflect step 2; build the 64-bit flags
// ST_DONE  | result presented until the consumer accepts it
module wide_op_sequencer
  import wide_op_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_fun_sel,
  output logic        alu_wf,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] result,
  output logic [3:0]  res_flags,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] a_q, a_d, b_q, b_d;
  logic [63:0] result_q, result_d;
  logic [3:0]  res_flags_q, res_flags_d;
  logic        res_valid_q, res_valid_d;
  logic        busy_q, busy_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]  fs_q, fs_d;
  logic        wf_q, wf_d;

  logic [2:0]  dec_op;
  logic [4:0]  dec_fs1, dec_fs2;
  logic        dec_high_first, dec_uses_c, dec_uses_v;

  // In IDLE the incoming op sets up step 1; afterwards the latched op rules.
  assign dec_op = (state_q == ST_IDLE) ? req_op : op_q;

  wide_op_decode u_decode (
    .op            (dec_op),
    .funsel1       (dec_fs1),
    .funsel2       (dec_fs2),
    .high_first    (dec_high_first),
    .uses_carry    (dec_uses_c),
    .uses_overflow (dec_uses_v)
  );

  // Next state, operand/result capture and next-cycle ALU drive values.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    res_flags_d = res_flags_q;
    res_valid_d = res_valid_q;
    alu_a_d     = '0;
    alu_b_d     = '0;
    fs_d        = FS_PASS;
    wf_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_STEP1;
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          alu_a_d = dec_high_first ? req_a[63:32] : req_a[31:0];
          alu_b_d = dec_high_first ? req_b[63:32] : req_b[31:0];
          fs_d    = dec_fs1;
          wf_d    = 1'b1;
        end
      end
      ST_STEP1: begin
        state_d = ST_STEP2;
        if (dec_high_first) result_d[63:32] = alu_out;
        else                result_d[31:0]  = alu_out;
        alu_a_d = dec_high_first ? a_q[31:0] : a_q[63:32];
        alu_b_d = dec_high_first ? b_q[31:0] : b_q[63:32];
        fs_d    = dec_fs2;
        wf_d    = 1'b1;
      end
      ST_STEP2: begin
        state_d = ST_CAPT;
        if (dec_high_first) result_d[31:0]  = alu_out;
        else                result_d[63:32] = alu_out;
      end
      ST_CAPT: begin
        state_d             = ST_DONE;
        res_flags_d         = '0;
        res_flags_d[FLAG_Z] = (result_q == '0);
        res_flags_d[FLAG_C] = dec_uses_c & alu_flags[FLAG_C];
        res_flags_d[FLAG_N] = result_q[63];
        res_flags_d[FLAG_V] = dec_uses_v & alu_flags[FLAG_V];
        res_valid_d         = 1'b1;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and all registered outputs; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      fs_q        <= FS_PASS;
      wf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      res_flags_q <= res_flags_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      fs_q        <= fs_d;
      wf_q        <= wf_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_fun_sel = fs_q;
  assign alu_wf      = wf_q;
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign res_flags   = res_flags_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_wide_op_sequencer.sv
// Bench for wide_op_sequencer: a behavioural 32-bit ALU sits downstream of
// the DUT and a 64-bit arithmetic reference model predicts every result.
module tb_wide_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_fun_sel;
  logic        alu_wf;
  logic [3:0]  alu_flags;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] result;
  logic [3:0]  res_flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  wide_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_fun_sel (alu_fun_sel),
    .alu_wf      (alu_wf),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .res_flags   (res_flags),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ALU model: combinational result, flag register {Z,C,N,V} written when WF=1.
  logic [3:0]  alu_flag_r = 4'b0000;
  logic [31:0] m_out;
  logic        m_c, m_v;
  always_comb begin
    m_out = '0;
    m_c   = alu_flag_r[2];
    m_v   = alu_flag_r[0];
    case (alu_fun_sel)
      5'b10000: m_out = alu_a;
      5'b10100: begin
        {m_c, m_out} = {1'b0, alu_a} + {1'b0, alu_b};
        m_v = (alu_a[31] == alu_b[31]) && (m_out[31] != alu_a[31]);
      end
      5'b10101: begin
        {m_c, m_out} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_flag_r[2]};
        m_v = (alu_a[31] == alu_b[31]) && (m_out[31] != alu_a[31]);
      end
      5'b10111: m_out = alu_a & alu_b;
      5'b11000: m_out = alu_a | alu_b;
      5'b11001: m_out = alu_a ^ alu_b;
      5'b11011: begin m_out = {alu_a[30:0], 1'b0};          m_c = alu_a[31]; end
      5'b11110: begin m_out = {alu_a[30:0], alu_flag_r[2]}; m_c = alu_a[31]; end
      5'b11100: begin m_out = {1'b0, alu_a[31:1]};          m_c = alu_a[0];  end
      5'b11111: begin m_out = {alu_flag_r[2], alu_a[31:1]}; m_c = alu_a[0];  end
      default: m_out = '0;
    endcase
  end
  assign alu_out   = m_out;
  assign alu_flags = alu_flag_r;

  always @(posedge clk) begin
    if (alu_wf) alu_flag_r <= {(m_out == 32'd0), m_c, m_out[31], m_v};
  end

  // 64-bit reference: returns {Z,C,N,V, result}.
  function automatic logic [67:0] ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0]; c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'd1: begin r = a << 1; c = a[63]; end
      3'd2: begin r = a >> 1; c = a[0]; end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      default: r = a;
    endcase
    return {(r == 64'd0), c, r[63], v, r};
  endfunction

  function automatic logic [9:0] exp_fs(input logic [2:0] op);
    case (op)
      3'd0: return {5'b10100, 5'b10101};
      3'd1: return {5'b11011, 5'b11110};
      3'd2: return {5'b11100, 5'b11111};
      3'd3: return {5'b10111, 5'b10111};
      3'd4: return {5'b11000, 5'b11000};
      3'd5: return {5'b11001, 5'b11001};
      default: return {5'b10000, 5'b10000};
    endcase
  endfunction

  // One full transaction with immediate result acceptance.
  task automatic run_txn(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output logic [3:0] flg, output int lat,
                         output logic [4:0] fs1, output logic [4:0] fs2, output logic wf_ok);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; fs1 = alu_fun_sel; wf_ok = alu_wf; fs2 = '0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (lat == 2) begin fs2 = alu_fun_sel; wf_ok = wf_ok & alu_wf; end
    end
    res = result; flg = res_flags;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_valid_busy got %b want 00", {res_valid, busy}); end
    checks++; if ({result, res_flags} !== 68'd0) begin errors++; $display("FAIL reset_result got %h/%b want 0/0000", result, res_flags); end
    checks++; if ({alu_fun_sel, alu_wf} !== 6'b100000) begin errors++; $display("FAIL reset_alu_ctl got %b/%b want 10000/0", alu_fun_sel, alu_wf); end
    checks++; if ({alu_a, alu_b} !== 64'd0) begin errors++; $display("FAIL reset_alu_ops got %h/%h want 0/0", alu_a, alu_b); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [7] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd5, 3'd7};
    logic [63:0] as  [7] = '{64'h00000000_FFFFFFFF, 64'h7FFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
                            64'h80000000_80000000, 64'h00000001_00000001, 64'h0F0F0F0F_F0F0F0F0,
                            64'h12345678_9ABCDEF0};
    logic [63:0] bs  [7] = '{64'd1, 64'd1, 64'd1, 64'hDEADBEEF_CAFEF00D, 64'h55555555_AAAAAAAA,
                            64'h0F0F0F0F_F0F0F0F0, 64'hFFFFFFFF_FFFFFFFF};
    logic [63:0] ers [7] = '{64'h00000001_00000000, 64'h80000000_00000000, 64'd0,
                            64'h00000001_00000000, 64'h00000000_80000000, 64'd0,
                            64'h12345678_9ABCDEF0};
    logic [3:0]  efs [7] = '{4'b0000, 4'b0011, 4'b1100, 4'b0100, 4'b0100, 4'b1000, 4'b0000};
    logic [63:0] res; logic [3:0] flg; int lat; logic [4:0] f1, f2; logic wok;
    for (int i = 0; i < 7; i++) begin
      run_txn(ops[i], as[i], bs[i], res, flg, lat, f1, f2, wok);
      checks++; if (res !== ers[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, ers[i]); end
      checks++; if (flg !== efs[i]) begin errors++; $display("FAIL dir%0d_flags got %b want %b", i, flg, efs[i]); end
      checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [63:0] a, b, res; logic [3:0] flg; int lat;
    logic [4:0] f1, f2; logic wok; logic [67:0] exp; logic [9:0] efs;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = ~a + 64'd1;
        1: a = {32'hFFFFFFFF, a[31:0]} | {32'd0, 32'h80000000};
        default: ;
      endcase
      exp = ref_op(op, a, b);
      efs = exp_fs(op);
      run_txn(op, a, b, res, flg, lat, f1, f2, wok);
      checks++; if ({flg, res} !== exp) begin errors++; $display("FAIL rnd%0d op%0d a=%h b=%h got %b/%h want %b/%h", i, op, a, b, flg, res, exp[67:64], exp[63:0]); end
      checks++; if ({f1, f2, wok} !== {efs, 1'b1}) begin errors++; $display("FAIL rnd%0d_funsel op%0d got %b/%b wf%b want %b/%b wf1", i, op, f1, f2, wok, efs[9:5], efs[4:0]); end
      checks++; if (lat != 4 || req_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_timing got lat%0d ready%b want lat4 ready1", i, lat, req_ready); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a1, b1, a2, b2; logic [67:0] e1, e2; int lat;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    e1 = ref_op(3'd0, a1, b1);
    e2 = ref_op(3'd4, a2, b2);
    req_op = 3'd0; req_a = a1; req_b = b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    req_op = 3'd4; req_a = a2; req_b = b2; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({res_valid, req_ready, busy, alu_wf, res_flags, result} !== {4'b1010, e1}) begin
        errors++;
        $display("FAIL bp_hold%0d got v%b r%b b%b wf%b %b/%h want v1 r0 b1 wf0 %b/%h", i, res_valid, req_ready, busy, alu_wf, res_flags, result, e1[67:64], e1[63:0]);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++; if ({res_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got v%b r%b want v0 r1", res_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if ({busy, req_ready} !== 2'b10) begin errors++; $display("FAIL bp_accept got b%b r%b want b1 r0", busy, req_ready); end
    lat = 1;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if ({res_flags, result} !== e2 || lat != 4) begin errors++; $display("FAIL bp_second got %b/%h lat%0d want %b/%h lat4", res_flags, result, lat, e2[67:64], e2[63:0]); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; logic [3:0] flg; int lat; logic [4:0] f1, f2; logic wok;
    run_txn(3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'd1, res, flg, lat, f1, f2, wok);
    req_op = 3'd0; req_a = 64'hFFFFFFFF_FFFFFFFF; req_b = 64'd1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, alu_fun_sel} !== 6'b110101) begin errors++; $display("FAIL mid_step2 got b%b fs%b want b1 fs10101", busy, alu_fun_sel); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, res_valid, busy, alu_wf, alu_fun_sel, alu_a, alu_b, result, res_flags} !== {4'b1000, 5'b10000, 64'd0, 64'd0, 4'd0}) begin
      errors++;
      $display("FAIL mid_reset got r%b v%b b%b wf%b fs%b a%h b%h %h/%b want reset values", req_ready, res_valid, busy, alu_wf, alu_fun_sel, alu_a, alu_b, result, res_flags);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(3'd0, 64'd1, 64'd1, res, flg, lat, f1, f2, wok);
    checks++; if ({flg, res} !== {4'b0000, 64'd2}) begin errors++; $display("FAIL mid_after got %b/%h want 0000/2", flg, res); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
